// File: rtl/sparse_pack_if.sv
// Dense-in / packed-out bundle for sparse_pack.
// Optional thr field exists only when THRESHOLD_EN is defined.
interface sparse_pack_if #(
    parameter int IL     = 8,
    parameter int FL     = 12,
    parameter int length = 32
);
    localparam int W = IL + FL;

    logic                input_ready;
    logic signed [W-1:0] in [length];
    logic                output_taken;
`ifdef THRESHOLD_EN
    logic [W-2:0]        thr;
`endif
    logic [length-1:0]   o_mask;
    logic signed [W-1:0] o_data [16];
    logic [4:0]          o_count;
    logic                overflow;
    logic [1:0]          state;

    modport master (
`ifdef THRESHOLD_EN
        output thr,
`endif
        output input_ready, in, output_taken,
        input  o_mask, o_data, o_count,
        input  overflow, state
    );

    modport slave (
`ifdef THRESHOLD_EN
        input  thr,
`endif
        input  input_ready, in, output_taken,
        output o_mask, o_data, o_count,
        output overflow, state
    );
endinterface

// File: rtl/sparse_pack.sv
// Serial sparse-vector compressor: presence mask plus 16 packed slots.
// Define THRESHOLD_EN to add a magnitude threshold on presence.
module sparse_pack #(
    parameter int IL       = 8,
    parameter int FL       = 12,
    parameter int length   = 32,
    parameter int p_length = $clog2(length)
) (
    input  logic          clk,
    input  logic          reset,
    sparse_pack_if.slave  bus
);
    localparam int W = IL + FL;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SCAN = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic signed [W-1:0]   vec_q [length];
    logic [p_length-1:0]   m_pointer;
    logic [4:0]            o_pointer;
    logic [length-1:0]     mask_q;
    logic signed [W-1:0]   data_q [16];
    logic                  ovf_q;
    logic signed [W-1:0]   elem;
    logic                  present;

    assign elem = vec_q[m_pointer];

`ifdef THRESHOLD_EN
    logic [W-2:0]        thr_q;
    logic signed [W-1:0] neg;
    logic [W-2:0]        mag;

    assign neg = -elem;

    // Negating the most negative value overflows; clamp it to max.
    always_comb begin
        mag = elem[W-2:0];
        if (elem[W-1])
            mag = neg[W-1] ? '1 : neg[W-2:0];
    end

    assign present = mag > thr_q;
`else
    assign present = elem != '0;
`endif

    always_ff @(posedge clk) begin
        if (!reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:
                if (bus.input_ready)
                    state_d = SCAN;
            SCAN:
                if (m_pointer == p_length'(length - 1))
                    state_d = DONE;
            DONE:
                if (bus.output_taken)
                    state_d = IDLE;
            default:
                state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < length; i++)
                vec_q[i] <= '0;
            for (int j = 0; j < 16; j++)
                data_q[j] <= '0;
            mask_q    <= '0;
            m_pointer <= '0;
            o_pointer <= '0;
            ovf_q     <= 1'b0;
`ifdef THRESHOLD_EN
            thr_q     <= '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.input_ready) begin
                        vec_q <= bus.in;
                        for (int j = 0; j < 16; j++)
                            data_q[j] <= '0;
                        mask_q    <= '0;
                        m_pointer <= '0;
                        o_pointer <= '0;
                        ovf_q     <= 1'b0;
`ifdef THRESHOLD_EN
                        thr_q     <= bus.thr;
`endif
                    end
                end
                SCAN: begin
                    if (present) begin
                        if (!o_pointer[4]) begin
                            data_q[o_pointer[3:0]] <= elem;
                            mask_q[m_pointer]      <= 1'b1;
                            o_pointer <= o_pointer + 5'd1;
                        end else begin
                            ovf_q <= 1'b1;
                        end
                    end
                    m_pointer <= m_pointer + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.o_mask   = mask_q;
    assign bus.o_data   = data_q;
    assign bus.o_count  = o_pointer;
    assign bus.overflow = ovf_q;
    assign bus.state    = state_q;
endmodule

// File: tb/tb_sparse_pack.sv
// Randomized and directed bench for sparse_pack against a queue model.
// Define THRESHOLD_EN to also exercise the magnitude threshold.
module tb_sparse_pack;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   thr_val = 0;

    logic signed [19:0] stim  [32];
    logic signed [19:0] stim2 [32];
    logic signed [19:0] exp_data [16];
    logic [31:0]        exp_mask;
    logic [4:0]         exp_cnt;
    logic               exp_ovf;

    sparse_pack_if bus ();

    sparse_pack dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic bit is_present(logic signed [19:0] v);
        int a;
        a = int'(v);
        if (a < 0) a = -a;
        if (a > 524287) a = 524287;
        return a > thr_val;
    endfunction

    task automatic model();
        logic signed [19:0] q [$];
        q = {};
        exp_mask = '0;
        exp_ovf  = 1'b0;
        for (int k = 0; k < 32; k++) begin
            if (is_present(stim[k])) begin
                if (q.size() < 16) begin
                    q.push_back(stim[k]);
                    exp_mask[k] = 1'b1;
                end else begin
                    exp_ovf = 1'b1;
                end
            end
        end
        exp_cnt = 5'(q.size());
        for (int j = 0; j < 16; j++)
            exp_data[j] = (j < q.size()) ? q[j] : 20'sd0;
    endtask

    task automatic check_results(string tag);
        chk({tag, "_mask"}, bus.o_mask, exp_mask);
        chk({tag, "_count"}, bus.o_count, exp_cnt);
        chk({tag, "_ovf"}, bus.overflow, exp_ovf);
        for (int j = 0; j < 16; j++)
            chk($sformatf("%s_data%0d", tag, j),
                bus.o_data[j], exp_data[j]);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.state !== 2'b00 && n < 100) begin
            step();
            n++;
        end
        chk("idle_wait", bus.state, 2'b00);
    endtask

    task automatic run(string tag, bit hold, bit pulse);
        wait_idle();
        model();
        bus.in          = stim;
`ifdef THRESHOLD_EN
        bus.thr         = 19'(thr_val);
`endif
        bus.input_ready = 1'b1;
        step();
        chk({tag, "_cap_state"}, bus.state, 2'b01);
        chk({tag, "_cap_ovf"}, bus.overflow, 1'b0);
        chk({tag, "_cap_cnt"}, bus.o_count, 5'd0);
        if (hold)
            bus.in = stim2;
        else
            bus.input_ready = 1'b0;
        for (int i = 1; i < 32; i++) begin
            bus.output_taken = pulse && (i == 5);
            step();
        end
        bus.output_taken = 1'b0;
        chk({tag, "_scan31"}, bus.state, 2'b01);
        step();
        chk({tag, "_done"}, bus.state, 2'b10);
        step();
        bus.input_ready = 1'b0;
        chk({tag, "_done_hold"}, bus.state, 2'b10);
        check_results(tag);
        bus.output_taken = 1'b1;
        step();
        bus.output_taken = 1'b0;
        chk({tag, "_taken"}, bus.state, 2'b00);
        chk({tag, "_kept_cnt"}, bus.o_count, exp_cnt);
    endtask

    task automatic clear_stim();
        for (int k = 0; k < 32; k++)
            stim[k] = '0;
    endtask

    initial begin
        reset            = 1'b0;
        bus.input_ready  = 1'b0;
        bus.output_taken = 1'b0;
`ifdef THRESHOLD_EN
        bus.thr          = '0;
`endif
        clear_stim();
        bus.in = stim;
        step();
        step();
        chk("rst_state", bus.state, 2'b00);
        chk("rst_mask", bus.o_mask, 32'h0);
        chk("rst_count", bus.o_count, 5'd0);
        chk("rst_ovf", bus.overflow, 1'b0);
        for (int j = 0; j < 16; j++)
            chk($sformatf("rst_data%0d", j), bus.o_data[j], 20'sd0);
        reset = 1'b1;
        step();

        clear_stim();
        stim[3]  = 20'sh00100;
        stim[17] = -20'sd5;
        stim[31] = 20'sh7FFFF;
        run("sparse", 1'b0, 1'b0);
        chk("sparse_lit_mask", bus.o_mask, 32'h80020008);
        chk("sparse_lit_d1", bus.o_data[1], -20'sd5);

        clear_stim();
        run("zero", 1'b0, 1'b0);
        chk("zero_lit_mask", bus.o_mask, 32'h0);

        for (int k = 0; k < 32; k++)
            stim[k] = 20'sd1;
        run("ones", 1'b0, 1'b0);
        chk("ones_lit_mask", bus.o_mask, 32'h0000FFFF);
        chk("ones_lit_ovf", bus.overflow, 1'b1);

        for (int k = 0; k < 32; k++) begin
            stim[k]  = (k % 3 == 0) ? 20'(k + 7) : 20'sd0;
            stim2[k] = 20'(k + 100);
        end
        run("hold", 1'b1, 1'b1);
        run("b2b", 1'b0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            int d;
            d = $urandom_range(0, 100);
            for (int k = 0; k < 32; k++)
                stim[k] = ($urandom_range(0, 99) < d)
                          ? 20'($urandom) : 20'sd0;
            run($sformatf("rand%0d", r), 1'b0, 1'b0);
        end

        for (int k = 0; k < 32; k++)
            stim[k] = 20'(k + 1);
        wait_idle();
        bus.in          = stim;
        bus.input_ready = 1'b1;
        step();
        bus.input_ready = 1'b0;
        for (int i = 0; i < 9; i++)
            step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("mid_state", bus.state, 2'b00);
        chk("mid_mask", bus.o_mask, 32'h0);
        chk("mid_count", bus.o_count, 5'd0);
        chk("mid_ovf", bus.overflow, 1'b0);
        for (int j = 0; j < 16; j++)
            chk($sformatf("mid_data%0d", j), bus.o_data[j], 20'sd0);
        bus.output_taken = 1'b1;
        step();
        bus.output_taken = 1'b0;
        chk("mid_taken", bus.state, 2'b00);

`ifdef THRESHOLD_EN
        clear_stim();
        stim[0] = 20'sd4;
        stim[1] = -20'sd5;
        stim[2] = 20'sd5;
        stim[3] = 20'sh80000;
        thr_val = 4;
        run("thr", 1'b0, 1'b0);
        chk("thr_lit_mask", bus.o_mask, 32'h0000000E);
        chk("thr_lit_d2", bus.o_data[2], 20'sh80000);
        thr_val = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/sparse_pack.md
Name: sparse_pack

Overview:
- Compressor for sparse activation vectors: takes a dense vector of `length` fixed-point values and produces a presence bitmask plus the nonzero values packed contiguously into 16 slots.
- Writer side of the mask/compacted-output format consumed by the mask-update stage: mask bit k set ⇔ element k present, and the j-th set bit corresponds to packed slot j.
- Serial scan, one element per cycle, with an idle/busy/done handshake matching the other mask blocks.

Parameters:
- IL, 8, integer bits of fixed-point value
- FL, 12, fractional bits of fixed-point value
- length, 32, dense vector length (power of two, ≥16)
- p_length, $clog2(length), scan pointer width

Ports:
- clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset (reset==0 resets on clk edge)
- input_ready  input  1  dense vector valid; sampled only in state 00
- in  input  signed [IL+FL-1:0] x length  dense input vector
- output_taken  input  1  consumer has taken results; sampled only in state 10
- o_mask  output  length  presence bitmask
- o_data  output  signed [IL+FL-1:0] x 16  packed nonzero values, slot 0 = lowest index
- o_count  output  5  number of valid packed slots (0..16)
- overflow  output  1  more than 16 nonzeros seen; excess dropped
- state  output  2  00 idle, 01 scanning, 10 done

Behaviour:
- Reset (reset==0 at edge):
  - state=00, o_mask=0, all o_data=0, o_count=0, overflow=0
  - internal input copy, m_pointer and o_pointer = 0
  - Applies in any state; a scan in progress is abandoned.
- State 00:
  - On input_ready=1: copy `in` into internal register, clear o_mask/o_data/o_count/overflow, m_pointer=0, o_pointer=0, go to 01.
  - input_ready in 01/10 is ignored; the register is not overwritten.
- State 01, each cycle, element e = reg[m_pointer]:
  - Element present when e != 0.
  - Present and o_pointer<16: o_data[o_pointer]<=e, o_mask[m_pointer]<=1, o_pointer++, o_count++.
  - Present and o_pointer==16: o_mask bit stays 0, overflow<=1 (sticky until next capture).
  - Absent: o_mask bit stays 0.
  - m_pointer++ each cycle, wraps to 0 after length-1.
  - When m_pointer==length-1 is processed, go to 10 on the same edge.
- Latency: capture at edge N; results complete and state==10 visible after edge N+length (32 scan cycles at default).
- State 10:
  - Outputs stable and valid.
  - On output_taken=1, go to 00; outputs hold their values until the next capture (not cleared).
  - output_taken in 00/01 is ignored.
- Unused slots o_data[o_count..15] are 0.
- Invariant: popcount(o_mask)==o_count ≤ 16.
- All outputs registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro THRESHOLD_EN.
- Defined:
  - Adds input port `thr`, unsigned [IL+FL-2:0], captured together with `in` on input_ready.
  - Element present only if |e| > thr.
  - |−2^(IL+FL−1)| saturates to 2^(IL+FL−1)−1.
  - thr=0 reproduces the base behaviour exactly.
- Undefined:
  - No `thr` port.
  - Present ⇔ e != 0.

Test Plan:
- Reset mid-scan:
  - Stimulus: capture a vector, assert reset=0 at scan cycle 10.
  - Required: next cycle state=00, o_mask=0, o_count=0, overflow=0, all o_data=0; subsequent output_taken has no effect.
- Sparse vector, in[3]=0x00100, in[17]=−5, in[31]=0x7FFFF, rest 0:
  - Required: after 32 cycles o_mask=0x80020008, o_count=3, o_data[0..2]=0x00100,−5,0x7FFFF, o_data[3..15]=0, overflow=0.
- All-zero vector:
  - Required: state 10 after exactly 32 cycles, o_mask=0, o_count=0.
  - output_taken=1 → state 00 next edge.
- All 32 elements = 1:
  - Required: o_mask=0x0000FFFF, o_count=16, all o_data=1, overflow=1.
  - New capture → overflow=0.
- Handshake:
  - input_ready held high through 01/10 with a different vector: first vector's results unaffected.
  - output_taken pulsed during 01: ignored.
  - Back-to-back capture on the cycle after returning to 00: second result correct.
- THRESHOLD_EN, thr=4, in[0]=4, in[1]=−5, in[2]=5, in[3]=−2^19:
  - Required: o_mask=0x0000000E, o_data[0..2]=−5,5,−2^19.
